// File: rtl/qtable_loader_if.sv
// qtable_loader_if: byte stream valid/ready link
// master drives data/valid, slave returns ready
interface qtable_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/qtable_loader.sv
// qtable_loader: framed byte stream to Q-table BRAM writer
// checks sync header and XOR checksum, unpacks 2-bit entries
module qtable_loader #(
  parameter int          DEPTH     = 59049,
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  qtable_loader_if.slave    strm,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [1:0]        dina,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    UNPACK,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [5:0]        sh;
  logic [1:0]        sub;
  logic [7:0]        csum;
  logic              last_entry;

  assign last_entry = (cnt == LAST);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and state-decoded outputs; ready never looks at valid
  always_comb begin
    state_nx      = state;
    strm.in_ready = 1'b0;
    wea           = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = HDR;
      end
      HDR: begin
        strm.in_ready = 1'b1;
        busy          = 1'b1;
        if (strm.in_valid)
          state_nx = (strm.in_data == SYNC_BYTE) ? LOAD : ERR;
      end
      LOAD: begin
        strm.in_ready = 1'b1;
        busy          = 1'b1;
        if (strm.in_valid) state_nx = UNPACK;
      end
      UNPACK: begin
        busy = 1'b1;
        wea  = 1'b1;
        if (last_entry)       state_nx = CSUM;
        else if (sub == 2'd3) state_nx = LOAD;
      end
      CSUM: begin
        strm.in_ready = 1'b1;
        busy          = 1'b1;
        if (strm.in_valid)
          state_nx = (strm.in_data == csum) ? DONE : ERR;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = HDR;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nx = HDR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath: checksum, entry counter and the BRAM address/data latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      addra <= '0;
      dina  <= 2'd0;
      sh    <= 6'd0;
      sub   <= 2'd0;
      csum  <= 8'd0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            cnt  <= '0;
            csum <= 8'd0;
          end
        end
        LOAD: begin
          if (strm.in_valid) begin
            csum  <= csum ^ strm.in_data;
            addra <= cnt;
            dina  <= strm.in_data[1:0];
            sh    <= strm.in_data[7:2];
            sub   <= 2'd0;
          end
        end
        UNPACK: begin
          if (!last_entry) begin
            cnt <= cnt + 1'b1;
            if (sub != 2'd3) begin
              addra <= cnt + 1'b1;
              dina  <= sh[1:0];
              sh    <= {2'b00, sh[5:2]};
              sub   <= sub + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
